// File: rtl/rv32im_id_ex_stage.sv
// ID/EX pipeline register for the RV32IM ALU. It detects load-use hazards, forwards operands and selects the ALU operands.
// Define RV32IM_IDEX_FWD_EN to enable EX/MEM and MEM/WB forwarding. Otherwise any pending write stalls ID.

module rv32im_id_ex_stage #(
   parameter int XLEN       = 32,
   parameter int REG_ADDR_W = 5,
   parameter int CTRL_W     = 5
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  id_valid,
   output logic                  id_ready,
   input  logic [XLEN-1:0]       id_pc,
   input  logic [XLEN-1:0]       id_rs1_val,
   input  logic [XLEN-1:0]       id_rs2_val,
   input  logic [XLEN-1:0]       id_imm,
   input  logic [REG_ADDR_W-1:0] id_rs1,
   input  logic [REG_ADDR_W-1:0] id_rs2,
   input  logic [REG_ADDR_W-1:0] id_rd,
   input  logic [CTRL_W-1:0]     id_alu_ctrl,
   input  logic                  id_use_imm,
   input  logic                  id_use_pc,
   input  logic                  id_reg_write,
   input  logic                  id_mem_read,
   input  logic                  id_mem_write,
   input  logic                  flush,
   input  logic                  ex_ready,
   input  logic [REG_ADDR_W-1:0] exmem_rd,
   input  logic                  exmem_reg_write,
   input  logic [XLEN-1:0]       exmem_result,
   input  logic [REG_ADDR_W-1:0] memwb_rd,
   input  logic                  memwb_reg_write,
   input  logic [XLEN-1:0]       memwb_result,
   output logic                  ex_valid,
   output logic [XLEN-1:0]       ex_a,
   output logic [XLEN-1:0]       ex_b,
   output logic [CTRL_W-1:0]     ex_alu_ctrl,
   output logic [XLEN-1:0]       ex_store_data,
   output logic [XLEN-1:0]       ex_pc,
   output logic [REG_ADDR_W-1:0] ex_rd,
   output logic                  ex_reg_write,
   output logic                  ex_mem_read,
   output logic                  ex_mem_write,
   output logic                  load_use_stall
);

   typedef struct packed {
      logic [XLEN-1:0]       pc;
      logic [XLEN-1:0]       rs1_val;
      logic [XLEN-1:0]       rs2_val;
      logic [XLEN-1:0]       imm;
      logic [REG_ADDR_W-1:0] rs1;
      logic [REG_ADDR_W-1:0] rs2;
      logic [REG_ADDR_W-1:0] rd;
      logic [CTRL_W-1:0]     alu_ctrl;
      logic                  use_imm;
      logic                  use_pc;
      logic                  reg_write;
      logic                  mem_read;
      logic                  mem_write;
   } ex_fields_t;

   ex_fields_t      r_f;
   ex_fields_t      w_in;
   logic            r_valid;
   logic            w_hazard_src;
   logic            w_load_use;
   logic            w_capture;
   logic            w_hold;
   logic [XLEN-1:0] w_fwd_rs1;
   logic [XLEN-1:0] w_fwd_rs2;

   assign w_in = '{pc: id_pc, rs1_val: id_rs1_val, rs2_val: id_rs2_val, imm: id_imm,
                   rs1: id_rs1, rs2: id_rs2, rd: id_rd, alu_ctrl: id_alu_ctrl,
                   use_imm: id_use_imm, use_pc: id_use_pc, reg_write: id_reg_write,
                   mem_read: id_mem_read, mem_write: id_mem_write};

`ifdef RV32IM_IDEX_FWD_EN
   assign w_hazard_src = r_f.mem_read;
`else
   // Without forwarding, any producer still in EX must retire before its consumer enters.
   assign w_hazard_src = r_f.reg_write;
   logic w_unused_fwd;
   assign w_unused_fwd = ^{exmem_rd, exmem_reg_write, exmem_result,
                           memwb_rd, memwb_reg_write, memwb_result};
`endif

   assign w_load_use = r_valid & w_hazard_src & (r_f.rd != '0) & id_valid &
                       ((r_f.rd == id_rs1) | (r_f.rd == id_rs2));
   assign id_ready   = (!r_valid | ex_ready) & !w_load_use & !flush;
   assign w_capture  = id_valid & id_ready;
   assign w_hold     = r_valid & !ex_ready;

   // NOTE: sequential state uses non-blocking assignments, so every flop samples values from before the edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_valid <= 1'b0;
         r_f     <= '0;
      end else if (flush) begin
         r_valid <= 1'b0;
      end else if (w_capture) begin
         r_valid <= 1'b1;
         r_f     <= w_in;
      end else if (w_hold) begin
`ifdef RV32IM_IDEX_FWD_EN
         // Keep the retiring MEM/WB value, because it disappears from the bypass once the stall ends.
         if (memwb_reg_write && (memwb_rd != '0)) begin
            if (memwb_rd == r_f.rs1) r_f.rs1_val <= memwb_result;
            if (memwb_rd == r_f.rs2) r_f.rs2_val <= memwb_result;
         end
`endif
      end else begin
         r_valid <= 1'b0;
      end
   end

   // NOTE: every combinational output is given a default first, so no path can infer a latch.
   always_comb begin
      w_fwd_rs1 = r_f.rs1_val;
      w_fwd_rs2 = r_f.rs2_val;
`ifdef RV32IM_IDEX_FWD_EN
      if (exmem_reg_write && (exmem_rd != '0) && (exmem_rd == r_f.rs1))
         w_fwd_rs1 = exmem_result;
      else if (memwb_reg_write && (memwb_rd != '0) && (memwb_rd == r_f.rs1))
         w_fwd_rs1 = memwb_result;
      if (exmem_reg_write && (exmem_rd != '0) && (exmem_rd == r_f.rs2))
         w_fwd_rs2 = exmem_result;
      else if (memwb_reg_write && (memwb_rd != '0) && (memwb_rd == r_f.rs2))
         w_fwd_rs2 = memwb_result;
`endif
   end

   assign ex_valid       = r_valid;
   assign ex_a           = r_f.use_pc  ? r_f.pc  : w_fwd_rs1;
   assign ex_b           = r_f.use_imm ? r_f.imm : w_fwd_rs2;
   assign ex_store_data  = w_fwd_rs2;
   assign ex_alu_ctrl    = r_f.alu_ctrl;
   assign ex_pc          = r_f.pc;
   assign ex_rd          = r_f.rd;
   assign ex_reg_write   = r_valid & r_f.reg_write;
   assign ex_mem_read    = r_valid & r_f.mem_read;
   assign ex_mem_write   = r_valid & r_f.mem_write;
   assign load_use_stall = w_load_use;

endmodule

// File: tb/tb_rv32im_id_ex_stage.sv
// Self-checking bench for rv32im_id_ex_stage. It runs directed test-plan steps and then random traffic.
// Every step is compared against a slot-level reference model.

module tb_rv32im_id_ex_stage;

`ifdef RV32IM_IDEX_FWD_EN
   localparam bit FWD = 1'b1;
`else
   localparam bit FWD = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst_n;
   logic        id_valid, id_ready;
   logic [31:0] id_pc, id_rs1_val, id_rs2_val, id_imm;
   logic [4:0]  id_rs1, id_rs2, id_rd, id_alu_ctrl;
   logic        id_use_imm, id_use_pc, id_reg_write, id_mem_read, id_mem_write;
   logic        flush, ex_ready;
   logic [4:0]  exmem_rd, memwb_rd;
   logic        exmem_reg_write, memwb_reg_write;
   logic [31:0] exmem_result, memwb_result;
   logic        ex_valid;
   logic [31:0] ex_a, ex_b, ex_store_data, ex_pc;
   logic [4:0]  ex_alu_ctrl, ex_rd;
   logic        ex_reg_write, ex_mem_read, ex_mem_write, load_use_stall;

   int n_checks = 0;
   int n_pass   = 0;
   int n_fail   = 0;

   rv32im_id_ex_stage dut (
      .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_ready(id_ready),
      .id_pc(id_pc), .id_rs1_val(id_rs1_val), .id_rs2_val(id_rs2_val), .id_imm(id_imm),
      .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .id_alu_ctrl(id_alu_ctrl),
      .id_use_imm(id_use_imm), .id_use_pc(id_use_pc), .id_reg_write(id_reg_write),
      .id_mem_read(id_mem_read), .id_mem_write(id_mem_write), .flush(flush), .ex_ready(ex_ready),
      .exmem_rd(exmem_rd), .exmem_reg_write(exmem_reg_write), .exmem_result(exmem_result),
      .memwb_rd(memwb_rd), .memwb_reg_write(memwb_reg_write), .memwb_result(memwb_result),
      .ex_valid(ex_valid), .ex_a(ex_a), .ex_b(ex_b), .ex_alu_ctrl(ex_alu_ctrl),
      .ex_store_data(ex_store_data), .ex_pc(ex_pc), .ex_rd(ex_rd), .ex_reg_write(ex_reg_write),
      .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write), .load_use_stall(load_use_stall)
   );

   always #5 clk = ~clk;

   // Reference model: the instruction occupying the EX slot, as ID handed it over.
   typedef struct packed {
      logic        v;
      logic [31:0] pc, r1v, r2v, imm;
      logic [4:0]  rs1, rs2, rd, ctrl;
      logic        use_imm, use_pc, rw, mr, mw;
   } slot_t;

   slot_t m = '0;

   function automatic logic [31:0] fwd(input logic [4:0] rs, input logic [31:0] stored);
      if (FWD && exmem_reg_write && exmem_rd != 5'd0 && exmem_rd == rs) return exmem_result;
      if (FWD && memwb_reg_write && memwb_rd != 5'd0 && memwb_rd == rs) return memwb_result;
      return stored;
   endfunction

   function automatic logic exp_stall();
      return m.v && id_valid && m.rd != 5'd0 && (m.rd == id_rs1 || m.rd == id_rs2) &&
             (FWD ? m.mr : m.rw);
   endfunction

   function automatic logic exp_ready();
      return (!m.v || ex_ready) && !exp_stall() && !flush;
   endfunction

   function automatic slot_t model_next();
      slot_t n;
      n = m;
      if (flush) n.v = 1'b0;
      else if (id_valid && exp_ready())
         n = '{v: 1'b1, pc: id_pc, r1v: id_rs1_val, r2v: id_rs2_val, imm: id_imm,
               rs1: id_rs1, rs2: id_rs2, rd: id_rd, ctrl: id_alu_ctrl, use_imm: id_use_imm,
               use_pc: id_use_pc, rw: id_reg_write, mr: id_mem_read, mw: id_mem_write};
      else if (m.v && !ex_ready) begin
         if (FWD && memwb_reg_write && memwb_rd != 5'd0) begin
            if (memwb_rd == m.rs1) n.r1v = memwb_result;
            if (memwb_rd == m.rs2) n.r2v = memwb_result;
         end
      end else n.v = 1'b0;
      return n;
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) m <= '0;
      else        m <= model_next();
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic check_all();
      logic [31:0] ea, eb;
      ea = m.use_pc  ? m.pc  : fwd(m.rs1, m.r1v);
      eb = m.use_imm ? m.imm : fwd(m.rs2, m.r2v);
      check("ex_valid", {31'd0, ex_valid}, {31'd0, m.v});
      check("id_ready", {31'd0, id_ready}, {31'd0, exp_ready()});
      check("load_use_stall", {31'd0, load_use_stall}, {31'd0, exp_stall()});
      check("ex_reg_write", {31'd0, ex_reg_write}, {31'd0, m.v & m.rw});
      check("ex_mem_read", {31'd0, ex_mem_read}, {31'd0, m.v & m.mr});
      check("ex_mem_write", {31'd0, ex_mem_write}, {31'd0, m.v & m.mw});
      if (m.v) begin
         check("ex_a", ex_a, ea);
         check("ex_b", ex_b, eb);
         check("ex_store_data", ex_store_data, fwd(m.rs2, m.r2v));
         check("ex_pc", ex_pc, m.pc);
         check("ex_rd", {27'd0, ex_rd}, {27'd0, m.rd});
         check("ex_alu_ctrl", {27'd0, ex_alu_ctrl}, {27'd0, m.ctrl});
      end
   endtask

   // Checks the current cycle after the inputs settle, then advances to the next falling edge.
   task automatic cycle();
      #2 check_all();
      @(negedge clk);
   endtask

   task automatic idle();
      id_valid = 0; id_pc = 0; id_rs1_val = 0; id_rs2_val = 0; id_imm = 0;
      id_rs1 = 0; id_rs2 = 0; id_rd = 0; id_alu_ctrl = 0; id_use_imm = 0; id_use_pc = 0;
      id_reg_write = 0; id_mem_read = 0; id_mem_write = 0; flush = 0;
   endtask

   task automatic clr_fwd();
      exmem_rd = 0; exmem_reg_write = 0; exmem_result = 0;
      memwb_rd = 0; memwb_reg_write = 0; memwb_result = 0;
   endtask

   task automatic set_instr(input logic [31:0] pc, r1v, r2v, imm, input logic [4:0] rs1, rs2, rd,
                            ctrl, input logic ui, up, rw, mr, mw);
      id_valid = 1; id_pc = pc; id_rs1_val = r1v; id_rs2_val = r2v; id_imm = imm;
      id_rs1 = rs1; id_rs2 = rs2; id_rd = rd; id_alu_ctrl = ctrl; id_use_imm = ui;
      id_use_pc = up; id_reg_write = rw; id_mem_read = mr; id_mem_write = mw;
   endtask

   initial begin
      rst_n = 0; ex_ready = 1; idle(); clr_fwd();
      #3;
      check("rst_valid", {31'd0, ex_valid}, 32'd0);
      check("rst_a", ex_a, 32'd0);
      check("rst_b", ex_b, 32'd0);
      check("rst_store", ex_store_data, 32'd0);
      check("rst_ctrl", {27'd0, ex_alu_ctrl}, 32'd0);
      @(negedge clk); rst_n = 1;
      cycle();

      // ADD x3,x1,x2 with x1=5, x2=7
      set_instr(32'h100, 32'd5, 32'd7, 32'd0, 5'd1, 5'd2, 5'd3, 5'd0, 0, 0, 1, 0, 0);
      cycle();
      idle();
      #1;
      check("add_valid", {31'd0, ex_valid}, 32'd1);
      check("add_a", ex_a, 32'd5);
      check("add_b", ex_b, 32'd7);
      check("add_ctrl", {27'd0, ex_alu_ctrl}, 32'd0);
      check("add_rd", {27'd0, ex_rd}, 32'd3);
      exmem_rd = 1; exmem_reg_write = 1; exmem_result = 32'h10;
      memwb_rd = 1; memwb_reg_write = 1; memwb_result = 32'h20;
      #1 check("fwd_exmem_priority", ex_a, FWD ? 32'h10 : 32'd5);
      exmem_rd = 0;
      #1 check("fwd_memwb_only", ex_a, FWD ? 32'h20 : 32'd5);
      memwb_rd = 0;
      #1 check("fwd_x0_stored", ex_a, 32'd5);
      check_all();
      clr_fwd();
      @(negedge clk);

      // LW x4 followed by the dependent SUB x5,x4,x1
      set_instr(32'h200, 32'h1000, 32'd0, 32'd8, 5'd1, 5'd0, 5'd4, 5'd0, 1, 0, 1, 1, 0);
      cycle();
      set_instr(32'h204, 32'hdead, 32'd3, 32'd0, 5'd4, 5'd1, 5'd5, 5'd1, 0, 0, 1, 0, 0);
      #1;
      check("lu_stall", {31'd0, load_use_stall}, 32'd1);
      check("lu_ready", {31'd0, id_ready}, 32'd0);
      cycle();
      #1;
      check("lu_bubble", {31'd0, ex_valid}, 32'd0);
      check("lu_ready_after", {31'd0, id_ready}, 32'd1);
      cycle();
      idle();
      memwb_rd = 4; memwb_reg_write = 1; memwb_result = 32'h1234;
      #1;
      check("lu_sub_valid", {31'd0, ex_valid}, 32'd1);
      check("lu_fwd_a", ex_a, FWD ? 32'h1234 : 32'hdead);
      check("lu_sub_ctrl", {27'd0, ex_alu_ctrl}, 32'd1);
      cycle();
      clr_fwd();

      // A three-cycle hold in which MEM/WB writes x2 during the second cycle
      set_instr(32'h300, 32'h11, 32'h22, 32'd0, 5'd1, 5'd2, 5'd6, 5'd6, 0, 0, 1, 0, 0);
      cycle();
      idle(); ex_ready = 0;
      cycle();
      memwb_rd = 2; memwb_reg_write = 1; memwb_result = 32'h99;
      #1 check("hold_b_c2", ex_b, FWD ? 32'h99 : 32'h22);
      cycle();
      clr_fwd();
      #1;
      check("hold_b_c3", ex_b, FWD ? 32'h99 : 32'h22);
      check("hold_valid", {31'd0, ex_valid}, 32'd1);
      check("hold_rd", {27'd0, ex_rd}, 32'd6);
      cycle();
      ex_ready = 1;
      #1 check("hold_b_release", ex_b, FWD ? 32'h99 : 32'h22);
      cycle();

      // A flush arrives while EX is full and ID also holds a valid instruction
      set_instr(32'h400, 32'h1, 32'h2, 32'd0, 5'd1, 5'd2, 5'd7, 5'd0, 0, 0, 1, 0, 0);
      cycle();
      set_instr(32'h404, 32'h3, 32'h4, 32'd0, 5'd1, 5'd2, 5'd8, 5'd0, 0, 0, 1, 0, 0);
      flush = 1;
      #1 check("fl_ready", {31'd0, id_ready}, 32'd0);
      cycle();
      idle();
      #1;
      check("fl_valid", {31'd0, ex_valid}, 32'd0);
      check("fl_reg_write", {31'd0, ex_reg_write}, 32'd0);
      cycle();

      // Flush and a load-use stall in the same cycle
      set_instr(32'h500, 32'h0, 32'h0, 32'd4, 5'd1, 5'd0, 5'd4, 5'd0, 1, 0, 1, 1, 0);
      cycle();
      set_instr(32'h504, 32'h0, 32'h0, 32'd0, 5'd4, 5'd1, 5'd5, 5'd1, 0, 0, 1, 0, 0);
      flush = 1;
      #1 check("fl_lu_stall", {31'd0, load_use_stall}, 32'd1);
      cycle();
      idle();
      #1 check("fl_lu_valid", {31'd0, ex_valid}, 32'd0);
      cycle();

      // Reset asserted while EX is holding a valid instruction
      set_instr(32'h600, 32'h55, 32'h66, 32'd0, 5'd1, 5'd2, 5'd9, 5'd2, 0, 0, 1, 0, 1);
      cycle();
      idle(); ex_ready = 0;
      #1 check("rst_mid_pre", {31'd0, ex_valid}, 32'd1);
      rst_n = 0;
      #1;
      check("rst_mid_valid", {31'd0, ex_valid}, 32'd0);
      check("rst_mid_a", ex_a, 32'd0);
      check("rst_mid_b", ex_b, 32'd0);
      check("rst_mid_mem_write", {31'd0, ex_mem_write}, 32'd0);
      @(negedge clk); rst_n = 1; ex_ready = 1;
      cycle();

      // Random traffic over a small register range so that hazards and bypass hits occur often
      for (int i = 0; i < 400; i++) begin
         rst_n        = ($urandom_range(0, 63) != 0);
         id_valid     = $urandom_range(0, 1);
         id_pc        = $urandom; id_rs1_val = $urandom; id_rs2_val = $urandom; id_imm = $urandom;
         id_rs1       = 5'($urandom_range(0, 3));
         id_rs2       = 5'($urandom_range(0, 3));
         id_rd        = 5'($urandom_range(0, 3));
         id_alu_ctrl  = 5'($urandom_range(0, 10));
         id_use_imm   = $urandom_range(0, 1);
         id_use_pc    = ($urandom_range(0, 3) == 0);
         id_reg_write = $urandom_range(0, 1);
         id_mem_read  = $urandom_range(0, 1);
         id_mem_write = $urandom_range(0, 1);
         flush        = ($urandom_range(0, 7) == 0);
         ex_ready     = ($urandom_range(0, 3) != 0);
         exmem_rd     = 5'($urandom_range(0, 3));
         exmem_reg_write = $urandom_range(0, 1);
         exmem_result = $urandom;
         memwb_rd     = 5'($urandom_range(0, 3));
         memwb_reg_write = $urandom_range(0, 1);
         memwb_result = $urandom;
         cycle();
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/rv32im_id_ex_stage.md
Name: rv32im_id_ex_stage

Overview:
- ID/EX pipeline register and operand-select stage directly upstream of the RV32IM ALU.
- Captures decoded instructions from ID with a valid/ready handshake and detects load-use hazards.
- Applies EX/MEM and MEM/WB forwarding and presents the final ALU operands a, b and alu_ctrl to the ALU.
- Supports stall (downstream backpressure) and flush (branch/jump redirect).

Parameters:
- XLEN, 32, datapath width.
- REG_ADDR_W, 5, register index width.
- CTRL_W, 5, ALU control width (matches ALU encoding: ADD=0, SUB=1 … REM=10).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- id_valid  in  1  ID holds a valid instruction.
- id_ready  out  1  stage accepts the ID instruction this cycle.
- id_pc  in  XLEN  instruction PC.
- id_rs1_val, id_rs2_val  in  XLEN  register-file read data.
- id_imm  in  XLEN  sign-extended immediate.
- id_rs1, id_rs2, id_rd  in  REG_ADDR_W  register indices.
- id_alu_ctrl  in  CTRL_W  ALU operation.
- id_use_imm  in  1  operand b = immediate.
- id_use_pc  in  1  operand a = PC (AUIPC/JAL).
- id_reg_write, id_mem_read, id_mem_write  in  1  control bits.
- flush  in  1  kill EX contents and incoming instruction.
- ex_ready  in  1  EX/MEM accepts the EX instruction.
- exmem_rd  in  REG_ADDR_W  forwarding source 1 destination index.
- exmem_reg_write  in  1  forwarding source 1 write enable.
- exmem_result  in  XLEN  forwarding source 1 data.
- memwb_rd  in  REG_ADDR_W  forwarding source 2 destination index.
- memwb_reg_write  in  1  forwarding source 2 write enable.
- memwb_result  in  XLEN  forwarding source 2 data.
- ex_valid  out  1  EX slot holds a valid instruction.
- ex_a, ex_b  out  XLEN  ALU operands.
- ex_alu_ctrl  out  CTRL_W  ALU control.
- ex_store_data  out  XLEN  forwarded rs2 value for stores.
- ex_pc  out  XLEN  PC of the EX instruction.
- ex_rd  out  REG_ADDR_W  destination index.
- ex_reg_write, ex_mem_read, ex_mem_write  out  1  control bits.
- load_use_stall  out  1  hazard indicator.

Behaviour:
- Reset (rst_n low, asynchronous): ex_valid=0; all registered fields=0 (alu_ctrl=ADD); ex_a=ex_b=ex_store_data=0.
- load_use_stall = ex_valid & ex_mem_read & ex_rd!=0 & (ex_rd==id_rs1 | ex_rd==id_rs2) & id_valid.
- id_ready = (!ex_valid | ex_ready) & !load_use_stall & !flush.
- Capture: on id_valid & id_ready, the register loads all id_* fields; ex_valid=1 next cycle. Latency 1 cycle ID→EX.
- Drain without capture: ex_ready & !(id_valid & id_ready) → ex_valid=0 (bubble); the load-use case always inserts exactly one bubble.
- Hold: ex_valid & !ex_ready → all fields held.
- Flush: priority over capture and hold → ex_valid=0 next cycle; id_ready=0 that cycle.
- Stored-operand refresh: while holding, if memwb_reg_write & memwb_rd!=0 & memwb_rd==stored rs1 (rs2), the stored rs1 (rs2) value updates to memwb_result. This prevents a stale value after the producer retires during the stall.
- Forwarding (combinational on the register outputs), per operand:
  - EX/MEM match (reg_write, rd!=0, rd==rs) takes priority.
  - Otherwise MEM/WB match.
  - Otherwise the stored value.
  - Register x0 is never forwarded.
- Operand select:
  - ex_a = use_pc ? pc : fwd_rs1.
  - ex_b = use_imm ? imm : fwd_rs2.
  - ex_store_data = fwd_rs2 always.
- Outputs are valid only when ex_valid=1; the control bits ex_reg_write, ex_mem_read and ex_mem_write are forced to 0 whenever ex_valid=0.
- Simultaneous flush & load_use_stall: flush wins, so the EX slot empties.
- Reset mid-stall: everything clears; no pending state is retained.

Optional Feature:
- Macro RV32IM_IDEX_FWD_EN.
- Defined: forwarding and stored-operand refresh as above.
- Undefined: the exmem_*/memwb_* inputs are ignored; ex_a/ex_b/ex_store_data use the stored values only. load_use_stall widens to any ex_valid & ex_reg_write & ex_rd!=0 & (ex_rd matches id_rs1 or id_rs2). Software or the upstream stage must cover MEM/WB distance.

Test Plan:
- Reset mid-transfer: assert rst_n=0 while ex_valid=1 → ex_valid=0, ex_a=ex_b=0 immediately, without waiting for clk.
- ADD x3,x1,x2 with x1=5, x2=7, ex_ready=1 → next cycle ex_valid=1, ex_a=5, ex_b=7, ex_alu_ctrl=0, ex_rd=3.
- EX/MEM rd=1 with result 0x10 and MEM/WB rd=1 with result 0x20 → ex_a=0x10 (EX/MEM priority). With rd=0 on both → stored value passes.
- LW x4 in EX, ID holds SUB x5,x4,x1 → load_use_stall=1, id_ready=0 for one cycle, one bubble (ex_valid=0), then SUB captured. The operand then comes from MEM/WB (load data 0x1234) → ex_a=0x1234.
- ex_ready=0 for 3 cycles with a MEM/WB write of x2=0x99 in cycle 2 → fields held, ex_b becomes 0x99 and remains until release.
- flush=1 with id_valid=1 and ex_valid=1 → next cycle ex_valid=0, ex_reg_write=0; the ID instruction is not captured.
